// File: rtl/lbp_pkg.sv
// Shared types and constants for the local branch predictor update queue.
package lbp_pkg;

  localparam int unsigned LBP_VLEN       = 64;
  localparam int unsigned LBP_INDEX_BITS = 7;
  localparam int unsigned LBP_DEPTH      = 8;

  // Pointer width: slot index bits plus one wrap (generation) bit.
  function automatic int unsigned lbp_ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int unsigned LBP_PTR_W = lbp_ptr_width(LBP_DEPTH);

  // One tracked branch between fetch-time prediction and in-order retirement.
  typedef struct packed {
    logic                      valid;
    logic                      resolved;
    logic                      taken;
    logic [LBP_VLEN-1:0]       pc;
    logic [LBP_INDEX_BITS-1:0] index;
  } lbp_uq_entry_t;

  // Predictor metadata carried with each prediction.
  typedef struct packed {
    logic [LBP_INDEX_BITS-1:0] index;
  } lbp_meta_t;

  // Same field layout as the local predictor's update port.
  typedef struct packed {
    logic                valid;
    logic [LBP_VLEN-1:0] pc;
    logic                taken;
    lbp_meta_t           metadata;
  } lbp_update_t;

endpackage

// File: rtl/lbp_uq_ptr.sv
// Head/tail pointer pair with wrap bits for the update queue: increment,
// tail reload on squash, full/empty detection, and a per-slot mask of the
// slots that are younger than a given tag.
module lbp_uq_ptr #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             head_inc,
  input  logic             tail_inc,
  input  logic             tail_load,
  input  logic [PTR_W-1:0] tail_load_val,
  input  logic [PTR_W-1:0] squash_tag,
  output logic [PTR_W-1:0] head,
  output logic [PTR_W-1:0] tail,
  output logic             empty,
  output logic             full,
  output logic [DEPTH-1:0] younger
);

  localparam int unsigned IDX_W = PTR_W - 1;

  logic [PTR_W-1:0] tag_off;

  // Head advances by one per retired entry; flush returns it to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
    end else if (clear) begin
      head <= '0;
    end else if (head_inc) begin
      head <= head + PTR_W'(1);
    end
  end

  // Tail advances on allocation, or snaps back just past a mispredicted branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tail <= '0;
    end else if (clear) begin
      tail <= '0;
    end else if (tail_load) begin
      tail <= tail_load_val;
    end else if (tail_inc) begin
      tail <= tail + PTR_W'(1);
    end
  end

  assign empty   = (head == tail);
  assign full    = (head[IDX_W-1:0] == tail[IDX_W-1:0]) && (head[PTR_W-1] != tail[PTR_W-1]);
  assign tag_off = squash_tag - head;

  // A slot is younger than the tag when its age relative to head exceeds the tag's age.
  always_comb begin
    logic [IDX_W-1:0] slot_off;
    younger  = '0;
    slot_off = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      slot_off   = IDX_W'(i) - head[IDX_W-1:0];
      younger[i] = ({1'b0, slot_off} > tag_off);
    end
  end

endmodule

// File: rtl/lbp_update_queue.sv
// In-order tracking queue for local branch predictor updates. Branches are
// allocated at fetch, resolved out of order from execute by tag, and retired
// one per cycle in program order into a registered predictor update.
// Entry and update storage use the package widths, so VLEN and INDEX_BITS
// must stay equal to LBP_VLEN and LBP_INDEX_BITS.
module lbp_update_queue
  import lbp_pkg::*;
#(
  parameter int unsigned VLEN       = LBP_VLEN,
  parameter int unsigned INDEX_BITS = LBP_INDEX_BITS,
  parameter int unsigned DEPTH      = LBP_DEPTH,
  parameter int unsigned PTR_W      = lbp_ptr_width(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_bp_i,
  input  logic                  debug_mode_i,
  input  logic                  push_valid_i,
  input  logic [VLEN-1:0]       push_pc_i,
  input  logic [INDEX_BITS-1:0] push_index_i,
  output logic                  push_ready_o,
  output logic [PTR_W-1:0]      push_tag_o,
  input  logic                  resolve_valid_i,
  input  logic [PTR_W-1:0]      resolve_tag_i,
  input  logic                  resolve_taken_i,
  input  logic                  resolve_mispredict_i,
  output logic                  upd_valid_o,
  output logic [VLEN-1:0]       upd_pc_o,
  output logic                  upd_taken_o,
  output logic [INDEX_BITS-1:0] upd_index_o
);

  localparam int unsigned IDX_W = PTR_W - 1;

  lbp_uq_entry_t    entries [DEPTH];
  logic [DEPTH-1:0] gen;
  lbp_update_t      upd_q;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             empty;
  logic             full;
  logic [DEPTH-1:0] younger;

  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-1:0] tail_idx;
  logic [IDX_W-1:0] res_idx;

  logic push_fire;
  logic res_hit;
  logic res_apply;
  logic squash;
  logic pop;

  assign head_idx = head[IDX_W-1:0];
  assign tail_idx = tail[IDX_W-1:0];
  assign res_idx  = resolve_tag_i[IDX_W-1:0];

  // Allocation is held off while full, flushing or squashing so the tail has one writer per cycle.
  assign push_ready_o = !full && !flush_bp_i && !(resolve_valid_i && resolve_mispredict_i);
  assign push_tag_o   = tail;
  assign push_fire    = push_valid_i && push_ready_o;

  // A resolve only lands on a live entry of the same pointer generation.
  assign res_hit   = resolve_valid_i && !flush_bp_i && entries[res_idx].valid
                     && (gen[res_idx] == resolve_tag_i[PTR_W-1]);
  assign res_apply = res_hit && !entries[res_idx].resolved;
  assign squash    = res_hit && resolve_mispredict_i;

  assign pop = !flush_bp_i && !empty && entries[head_idx].valid && entries[head_idx].resolved;

  lbp_uq_ptr #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ptr (
    .clk           (clk_i),
    .rst_n         (rst_ni),
    .clear         (flush_bp_i),
    .head_inc      (pop),
    .tail_inc      (push_fire),
    .tail_load     (squash),
    .tail_load_val (resolve_tag_i + PTR_W'(1)),
    .squash_tag    (resolve_tag_i),
    .head          (head),
    .tail          (tail),
    .empty         (empty),
    .full          (full),
    .younger       (younger)
  );

  // Entry state: allocate at tail, mark resolved by tag, retire at head, kill younger on squash.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries[i] <= '0;
      end
      gen <= '0;
    end else if (flush_bp_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries[i].valid    <= 1'b0;
        entries[i].resolved <= 1'b0;
      end
    end else begin
      if (pop) begin
        entries[head_idx].valid    <= 1'b0;
        entries[head_idx].resolved <= 1'b0;
      end
      if (push_fire) begin
        entries[tail_idx].valid    <= 1'b1;
        entries[tail_idx].resolved <= 1'b0;
        entries[tail_idx].taken    <= 1'b0;
        entries[tail_idx].pc       <= push_pc_i;
        entries[tail_idx].index    <= push_index_i;
        gen[tail_idx]              <= tail[PTR_W-1];
      end
      if (res_apply) begin
        entries[res_idx].resolved <= 1'b1;
        entries[res_idx].taken    <= resolve_taken_i;
      end
      if (squash) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (younger[i]) begin
            entries[i].valid    <= 1'b0;
            entries[i].resolved <= 1'b0;
          end
        end
      end
    end
  end

  // Registered predictor update: pulses for each retired entry unless in debug mode.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      upd_q <= '0;
    end else if (pop) begin
      upd_q.valid          <= !debug_mode_i;
      upd_q.pc             <= entries[head_idx].pc;
      upd_q.taken          <= entries[head_idx].taken;
      upd_q.metadata.index <= entries[head_idx].index;
    end else begin
      upd_q.valid <= 1'b0;
    end
  end

  assign upd_valid_o = upd_q.valid;
  assign upd_pc_o    = upd_q.pc;
  assign upd_taken_o = upd_q.taken;
  assign upd_index_o = upd_q.metadata.index;

endmodule

// File: tb/tb_lbp_update_queue.sv
// Directed bench for lbp_update_queue: in-order retirement, full/wrap,
// mispredict squash, flush, debug suppression and asynchronous reset.
module tb_lbp_update_queue;

  localparam int VLEN  = 64;
  localparam int IB    = 7;
  localparam int DEPTH = 8;
  localparam int PTR_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             flush_bp;
  logic             debug_mode;
  logic             push_valid;
  logic [VLEN-1:0]  push_pc;
  logic [IB-1:0]    push_index;
  logic             push_ready;
  logic [PTR_W-1:0] push_tag;
  logic             resolve_valid;
  logic [PTR_W-1:0] resolve_tag;
  logic             resolve_taken;
  logic             resolve_mispredict;
  logic             upd_valid;
  logic [VLEN-1:0]  upd_pc;
  logic             upd_taken;
  logic [IB-1:0]    upd_index;

  int errors = 0;
  int checks = 0;
  int upd_pulses = 0;
  int base;

  lbp_update_queue #(
    .VLEN       (VLEN),
    .INDEX_BITS (IB),
    .DEPTH      (DEPTH),
    .PTR_W      (PTR_W)
  ) dut (
    .clk_i                (clk),
    .rst_ni               (rst_n),
    .flush_bp_i           (flush_bp),
    .debug_mode_i         (debug_mode),
    .push_valid_i         (push_valid),
    .push_pc_i            (push_pc),
    .push_index_i         (push_index),
    .push_ready_o         (push_ready),
    .push_tag_o           (push_tag),
    .resolve_valid_i      (resolve_valid),
    .resolve_tag_i        (resolve_tag),
    .resolve_taken_i      (resolve_taken),
    .resolve_mispredict_i (resolve_mispredict),
    .upd_valid_o          (upd_valid),
    .upd_pc_o             (upd_pc),
    .upd_taken_o          (upd_taken),
    .upd_index_o          (upd_index)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Count every update pulse the predictor would see.
  always @(negedge clk) begin
    if (rst_n && upd_valid) upd_pulses++;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic pv, input logic [VLEN-1:0] pc, input logic [IB-1:0] idx,
                               input logic rv, input logic [PTR_W-1:0] rtag,
                               input logic rtaken, input logic rmisp);
    push_valid         = pv;
    push_pc            = pc;
    push_index         = idx;
    resolve_valid      = rv;
    resolve_tag        = rtag;
    resolve_taken      = rtaken;
    resolve_mispredict = rmisp;
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic pushEntry(input logic [VLEN-1:0] pc, input logic [IB-1:0] idx,
                           input logic [PTR_W-1:0] exp_tag, input string tag);
    applyStimulus(1'b1, pc, idx, 1'b0, '0, 1'b0, 1'b0);
    #1;
    checkOutput(tag, 64'(push_tag), 64'(exp_tag));
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic resolveEntry(input logic [PTR_W-1:0] rtag, input logic rtaken, input logic rmisp);
    applyStimulus(1'b0, '0, '0, 1'b1, rtag, rtaken, rmisp);
    tick();
    idle();
  endtask

  task automatic doReset();
    idle();
    flush_bp   = 1'b0;
    debug_mode = 1'b0;
    rst_n      = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    idle();
    flush_bp   = 1'b0;
    debug_mode = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_upd_valid", 64'(upd_valid), 64'd0);
    checkOutput("reset_upd_pc", upd_pc, 64'd0);
    checkOutput("reset_push_ready", 64'(push_ready), 64'd1);
    checkOutput("reset_push_tag", 64'(push_tag), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // In-order retirement of out-of-order resolves
    pushEntry(64'h100, 7'd1, 4'd0, "t1_tag0");
    pushEntry(64'h104, 7'd2, 4'd1, "t1_tag1");
    pushEntry(64'h108, 7'd3, 4'd2, "t1_tag2");
    resolveEntry(4'd2, 1'b1, 1'b0);
    checkOutput("t1_no_upd_after_tag2", 64'(upd_valid), 64'd0);
    resolveEntry(4'd1, 1'b0, 1'b0);
    checkOutput("t1_no_upd_after_tag1", 64'(upd_valid), 64'd0);
    resolveEntry(4'd0, 1'b1, 1'b0);
    checkOutput("t1_no_upd_one_cycle", 64'(upd_valid), 64'd0);
    tick();
    checkOutput("t1_u0_valid", 64'(upd_valid), 64'd1);
    checkOutput("t1_u0_pc", upd_pc, 64'h100);
    checkOutput("t1_u0_taken", 64'(upd_taken), 64'd1);
    checkOutput("t1_u0_index", 64'(upd_index), 64'd1);
    tick();
    checkOutput("t1_u1_valid", 64'(upd_valid), 64'd1);
    checkOutput("t1_u1_pc", upd_pc, 64'h104);
    checkOutput("t1_u1_taken", 64'(upd_taken), 64'd0);
    checkOutput("t1_u1_index", 64'(upd_index), 64'd2);
    tick();
    checkOutput("t1_u2_valid", 64'(upd_valid), 64'd1);
    checkOutput("t1_u2_pc", upd_pc, 64'h108);
    checkOutput("t1_u2_taken", 64'(upd_taken), 64'd1);
    checkOutput("t1_u2_index", 64'(upd_index), 64'd3);
    tick();
    checkOutput("t1_idle_valid", 64'(upd_valid), 64'd0);
    checkOutput("t1_idle_pc_hold", upd_pc, 64'h108);

    // Full queue, rejected push, pointer wrap and generation check
    doReset();
    base = upd_pulses;
    for (int i = 0; i < DEPTH; i++) begin
      pushEntry(64'h200 + 64'(4 * i), 7'(8 + i), 4'(i), "t2_fill_tag");
    end
    checkOutput("t2_full_ready", 64'(push_ready), 64'd0);
    applyStimulus(1'b1, 64'h300, 7'd5, 1'b1, 4'd0, 1'b1, 1'b0);
    #1;
    checkOutput("t2_reject_ready", 64'(push_ready), 64'd0);
    checkOutput("t2_reject_tag", 64'(push_tag), 64'd8);
    @(posedge clk);
    #1;
    idle();
    checkOutput("t2_pop_cycle_ready", 64'(push_ready), 64'd0);
    tick();
    checkOutput("t2_after_pop_ready", 64'(push_ready), 64'd1);
    checkOutput("t2_after_pop_tag", 64'(push_tag), 64'd8);
    checkOutput("t2_u0_valid", 64'(upd_valid), 64'd1);
    checkOutput("t2_u0_pc", upd_pc, 64'h200);
    checkOutput("t2_u0_index", 64'(upd_index), 64'd8);
    pushEntry(64'h300, 7'd5, 4'd8, "t2_wrap_tag");
    checkOutput("t2_refull_ready", 64'(push_ready), 64'd0);
    resolveEntry(4'd0, 1'b1, 1'b0);
    for (int i = 1; i < DEPTH; i++) begin
      resolveEntry(4'(i), 1'b1, 1'b0);
    end
    tick();
    tick();
    tick();
    checkOutput("t2_drain_count", 64'(upd_pulses - base), 64'd8);
    checkOutput("t2_gen_blocked", 64'(upd_valid), 64'd0);
    resolveEntry(4'd8, 1'b0, 1'b0);
    tick();
    checkOutput("t2_wrap_valid", 64'(upd_valid), 64'd1);
    checkOutput("t2_wrap_pc", upd_pc, 64'h300);
    checkOutput("t2_wrap_taken", 64'(upd_taken), 64'd0);
    checkOutput("t2_wrap_index", 64'(upd_index), 64'd5);

    // Mispredict squash of younger entries
    doReset();
    for (int i = 0; i < 5; i++) begin
      pushEntry(64'h400 + 64'(4 * i), 7'(i), 4'(i), "t3_push_tag");
    end
    applyStimulus(1'b0, '0, '0, 1'b1, 4'd1, 1'b0, 1'b1);
    #1;
    checkOutput("t3_misp_ready", 64'(push_ready), 64'd0);
    @(posedge clk);
    #1;
    idle();
    checkOutput("t3_tail_after_squash", 64'(push_tag), 64'd2);
    resolveEntry(4'd3, 1'b1, 1'b0);
    pushEntry(64'h500, 7'd9, 4'd2, "t3_reuse_tag");
    resolveEntry(4'd0, 1'b1, 1'b0);
    checkOutput("t3_pre_upd", 64'(upd_valid), 64'd0);
    tick();
    checkOutput("t3_u0_pc", upd_pc, 64'h400);
    checkOutput("t3_u0_taken", 64'(upd_taken), 64'd1);
    tick();
    checkOutput("t3_u1_valid", 64'(upd_valid), 64'd1);
    checkOutput("t3_u1_pc", upd_pc, 64'h404);
    checkOutput("t3_u1_taken", 64'(upd_taken), 64'd0);
    tick();
    checkOutput("t3_stall_unresolved", 64'(upd_valid), 64'd0);
    resolveEntry(4'd2, 1'b1, 1'b0);
    tick();
    checkOutput("t3_u2_valid", 64'(upd_valid), 64'd1);
    checkOutput("t3_u2_pc", upd_pc, 64'h500);
    checkOutput("t3_u2_index", 64'(upd_index), 64'd9);
    tick();
    checkOutput("t3_squashed_gone", 64'(upd_valid), 64'd0);
    checkOutput("t3_next_tag", 64'(push_tag), 64'd3);

    // Flush drops resolved entries without emitting updates
    doReset();
    base = upd_pulses;
    for (int i = 0; i < 4; i++) begin
      pushEntry(64'h600 + 64'(4 * i), 7'(20 + i), 4'(i), "t4_push_tag");
    end
    resolveEntry(4'd3, 1'b1, 1'b0);
    resolveEntry(4'd2, 1'b1, 1'b0);
    resolveEntry(4'd1, 1'b1, 1'b0);
    resolveEntry(4'd0, 1'b1, 1'b0);
    flush_bp = 1'b1;
    tick();
    flush_bp = 1'b0;
    checkOutput("t4_flush_upd", 64'(upd_valid), 64'd0);
    tick();
    tick();
    tick();
    checkOutput("t4_no_pulses", 64'(upd_pulses - base), 64'd0);
    checkOutput("t4_ready", 64'(push_ready), 64'd1);
    checkOutput("t4_tag", 64'(push_tag), 64'd0);

    // Debug mode suppresses update pulses but entries still retire
    doReset();
    base = upd_pulses;
    debug_mode = 1'b1;
    pushEntry(64'h680, 7'd4, 4'd0, "t5_tag0");
    pushEntry(64'h684, 7'd5, 4'd1, "t5_tag1");
    resolveEntry(4'd0, 1'b1, 1'b0);
    resolveEntry(4'd1, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    debug_mode = 1'b0;
    checkOutput("t5_debug_pulses", 64'(upd_pulses - base), 64'd0);
    pushEntry(64'h700, 7'h7f, 4'd2, "t5_tag2");
    resolveEntry(4'd2, 1'b0, 1'b0);
    tick();
    checkOutput("t5_u_valid", 64'(upd_valid), 64'd1);
    checkOutput("t5_u_pc", upd_pc, 64'h700);
    checkOutput("t5_u_index", 64'(upd_index), 64'h7f);
    tick();
    tick();
    checkOutput("t5_one_pulse", 64'(upd_pulses - base), 64'd1);

    // Asynchronous reset with entries pending
    doReset();
    pushEntry(64'h800, 7'd1, 4'd0, "t6_tag0");
    pushEntry(64'h804, 7'd2, 4'd1, "t6_tag1");
    pushEntry(64'h808, 7'd3, 4'd2, "t6_tag2");
    resolveEntry(4'd0, 1'b1, 1'b0);
    tick();
    checkOutput("t6_pre_valid", 64'(upd_valid), 64'd1);
    rst_n = 1'b0;
    #2;
    checkOutput("t6_async_valid", 64'(upd_valid), 64'd0);
    checkOutput("t6_async_pc", upd_pc, 64'd0);
    checkOutput("t6_async_taken", 64'(upd_taken), 64'd0);
    checkOutput("t6_async_index", 64'(upd_index), 64'd0);
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("t6_ready", 64'(push_ready), 64'd1);
    checkOutput("t6_tag", 64'(push_tag), 64'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
